// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - round-robin arbiter/controller for the shared data RAM
module data_mem_arbiter #(
  parameter int CORE_COUNT = 4,
  parameter int WIDTH      = 12,
  parameter int DEPTH      = 4096,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CORE_COUNT-1:0]          req,
  input  logic [CORE_COUNT-1:0]          wrEn,
  input  logic [CORE_COUNT*ADDR_WIDTH-1:0] addr,
  input  logic [CORE_COUNT*WIDTH-1:0]    dataIn,
  output logic [CORE_COUNT-1:0]          ack,
  output logic [WIDTH-1:0]               dataOut,
  output logic                           busy,
  output logic                           mem_wrEn,
  output logic [ADDR_WIDTH-1:0]          mem_addr,
  output logic [WIDTH-1:0]               mem_dataIn,
  input  logic [WIDTH-1:0]               mem_dataOut
);

  localparam int IDX_W = (CORE_COUNT > 1) ? $clog2(CORE_COUNT) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    ACK     = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]      g_q, g_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]      data_q, data_d;
  logic                  we_q, we_d;
  logic [WIDTH-1:0]      rdata_q, rdata_d;

  logic                  found;
  logic [IDX_W-1:0]      win;
  logic [IDX_W-1:0]      idx;

  // Round-robin search: first requester at or after rr_ptr, wrapping modulo CORE_COUNT.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < CORE_COUNT; k++) begin
      idx = IDX_W'((int'(rr_ptr_q) + k) % CORE_COUNT);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Next-state logic: one transaction at a time, loads take an extra CAPTURE cycle.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    g_d      = g_q;
    addr_d   = addr_q;
    data_d   = data_q;
    we_d     = we_q;
    rdata_d  = rdata_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          g_d     = win;
          addr_d  = addr[win*ADDR_WIDTH +: ADDR_WIDTH];
          data_d  = dataIn[win*WIDTH +: WIDTH];
          we_d    = wrEn[win];
          state_d = ISSUE;
        end
      end
      ISSUE:   state_d = we_q ? ACK : CAPTURE;
      CAPTURE: begin
        rdata_d = mem_dataOut;
        state_d = ACK;
      end
      ACK: begin
        rr_ptr_d = (g_q == IDX_W'(CORE_COUNT - 1)) ? '0 : g_q + 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and transaction registers; reset abandons any in-flight transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      g_q      <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      we_q     <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      g_q      <= g_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      we_q     <= we_d;
      rdata_q  <= rdata_d;
    end
  end

  // RAM drive and core-side outputs; address/data registers only change on entry to ISSUE,
  // so the RAM lines naturally hold their last values in every other state.
  always_comb begin
    ack        = '0;
    if (state_q == ACK) ack[g_q] = 1'b1;
    dataOut    = rdata_q;
    busy       = (state_q != IDLE);
    mem_wrEn   = (state_q == ISSUE) && we_q;
    mem_addr   = addr_q;
    mem_dataIn = data_q;
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - directed self-checking bench for data_mem_arbiter
module tb_data_mem_arbiter;

  localparam int NC = 4;
  localparam int W  = 12;
  localparam int AW = 12;

  logic             clk;
  logic             rst;
  logic [NC-1:0]    req;
  logic [NC-1:0]    wrEn;
  logic [NC*AW-1:0] addr;
  logic [NC*W-1:0]  dataIn;
  logic [NC-1:0]    ack;
  logic [W-1:0]     dataOut;
  logic             busy;
  logic             mem_wrEn;
  logic [AW-1:0]    mem_addr;
  logic [W-1:0]     mem_dataIn;
  logic [W-1:0]     mem_dataOut;

  int n_checks;
  int n_fail;
  int wr_cycles;

  logic [W-1:0]  ram [0:4095];
  logic [AW-1:0] ram_addr_q;

  data_mem_arbiter #(.CORE_COUNT(NC), .WIDTH(W), .DEPTH(4096), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .req(req), .wrEn(wrEn), .addr(addr), .dataIn(dataIn),
    .ack(ack), .dataOut(dataOut), .busy(busy), .mem_wrEn(mem_wrEn),
    .mem_addr(mem_addr), .mem_dataIn(mem_dataIn), .mem_dataOut(mem_dataOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: registered address, synchronous write, read data one cycle after address.
  always @(posedge clk) begin
    if (mem_wrEn) ram[mem_addr] <= mem_dataIn;
    ram_addr_q <= mem_addr;
  end
  assign mem_dataOut = ram[ram_addr_q];

  always @(negedge clk) if (mem_wrEn) wr_cycles++;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic set_core(input int core, input bit we, input logic [AW-1:0] a, input logic [W-1:0] d);
    req[core]              = 1'b1;
    wrEn[core]             = we;
    addr[core*AW +: AW]    = a;
    dataIn[core*W +: W]    = d;
  endtask

  // Single transaction from one core; latency counted in edges after the request is raised.
  task automatic run_txn(input string tag, input int core, input bit we, input logic [AW-1:0] a,
                         input logic [W-1:0] d, input int exp_lat, input logic [W-1:0] exp_data);
    int n;
    bit got;
    set_core(core, we, a, d);
    n = 0;
    got = 1'b0;
    while (!got && n < 12) begin
      step();
      n++;
      if (ack != '0) got = 1'b1;
    end
    check_eq({tag, " ack seen"}, 32'(got), 32'd1);
    check_eq({tag, " ack vector"}, 32'(ack), 32'(1 << core));
    check_eq({tag, " latency"}, 32'(n), 32'(exp_lat));
    if (!we) check_eq({tag, " dataOut"}, 32'(dataOut), 32'(exp_data));
    req[core] = 1'b0;
    step();
    check_eq({tag, " ack one cycle"}, 32'(ack), 32'd0);
    check_eq({tag, " idle after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int snap;
    int n;
    int k;
    int last;
    int exp_order [4];
    logic [12:0] wide;

    n_checks = 0;
    n_fail = 0;
    wr_cycles = 0;
    for (int i = 0; i < 4096; i++) ram[i] = '0;
    rst = 1'b1;
    req = '0;
    wrEn = '0;
    addr = '0;
    dataIn = '0;
    #2;
    check_eq("reset ack", 32'(ack), 32'd0);
    check_eq("reset dataOut", 32'(dataOut), 32'd0);
    check_eq("reset busy", 32'(busy), 32'd0);
    check_eq("reset mem_wrEn", 32'(mem_wrEn), 32'd0);
    check_eq("reset mem_addr", 32'(mem_addr), 32'd0);
    check_eq("reset mem_dataIn", 32'(mem_dataIn), 32'd0);
    step();
    rst = 1'b0;
    step();

    // Test 1: store from core0.
    snap = wr_cycles;
    set_core(0, 1'b1, 12'h005, 12'h3A7);
    step();
    check_eq("t1 issue mem_wrEn", 32'(mem_wrEn), 32'd1);
    check_eq("t1 issue mem_addr", 32'(mem_addr), 32'h005);
    check_eq("t1 issue mem_dataIn", 32'(mem_dataIn), 32'h3A7);
    check_eq("t1 busy", 32'(busy), 32'd1);
    step();
    check_eq("t1 ack at E1", 32'(ack), 32'b0001);
    check_eq("t1 mem_wrEn dropped", 32'(mem_wrEn), 32'd0);
    req[0] = 1'b0;
    step();
    check_eq("t1 ack cleared", 32'(ack), 32'd0);
    check_eq("t1 write pulse count", 32'(wr_cycles - snap), 32'd1);
    check_eq("t1 ram[5]", 32'(ram[5]), 32'h3A7);
    check_eq("t1 dataOut unchanged by store", 32'(dataOut), 32'd0);
    check_eq("t1 mem_addr holds", 32'(mem_addr), 32'h005);

    // Test 2: load by core2 of the stored word.
    run_txn("t2 load core2", 2, 1'b0, 12'h005, 12'h000, 3, 12'h3A7);
    check_eq("t2 dataOut held", 32'(dataOut), 32'h3A7);

    // Test 3: all four cores load at once from rr_ptr=0.
    do_reset();
    ram[12'h100] = 12'h111;
    ram[12'h101] = 12'h222;
    ram[12'h102] = 12'h333;
    ram[12'h103] = 12'h444;
    for (int i = 0; i < NC; i++) set_core(i, 1'b0, AW'(12'h100 + i), '0);
    k = 0;
    n = 0;
    last = 0;
    while (k < 4 && n < 40) begin
      step();
      n++;
      if (ack != '0) begin
        check_eq("t3 ack order", 32'(ack), 32'(1 << k));
        check_eq("t3 load data", 32'(dataOut), 32'(12'h111 * (k + 1)));
        if (k == 0) check_eq("t3 first latency", 32'(n), 32'd3);
        else check_eq("t3 ack spacing", 32'(n - last), 32'd4);
        last = n;
        req[k] = 1'b0;
        k++;
      end
    end
    check_eq("t3 all four served", 32'(k), 32'd4);
    step();

    // Test 4: cores 1 and 3 hold req continuously; grants must alternate.
    do_reset();
    exp_order[0] = 1;
    exp_order[1] = 3;
    exp_order[2] = 1;
    exp_order[3] = 3;
    set_core(1, 1'b0, 12'h101, '0);
    set_core(3, 1'b0, 12'h103, '0);
    k = 0;
    n = 0;
    while (k < 4 && n < 40) begin
      step();
      n++;
      if (ack != '0) begin
        check_eq("t4 alternating grant", 32'(ack), 32'(1 << exp_order[k]));
        k++;
      end
    end
    check_eq("t4 four grants", 32'(k), 32'd4);
    req = '0;
    step();
    step();

    // Test 5: top-of-memory store/load and address truncation.
    run_txn("t5 store fff", 0, 1'b1, 12'hFFF, 12'hFFF, 2, 12'h000);
    check_eq("t5 ram[fff]", 32'(ram[12'hFFF]), 32'hFFF);
    run_txn("t5 load fff", 1, 1'b0, 12'hFFF, 12'h000, 3, 12'hFFF);
    wide = 13'h1000;
    run_txn("t5 store wrap", 2, 1'b1, wide[11:0], 12'h5A5, 2, 12'h000);
    check_eq("t5 wrapped to ram[0]", 32'(ram[0]), 32'h5A5);
    check_eq("t5 dataOut kept", 32'(dataOut), 32'hFFF);

    // Test 6: reset during ISSUE of a store discards it.
    snap = wr_cycles;
    set_core(3, 1'b1, 12'h010, 12'h123);
    step();
    check_eq("t6 in issue", 32'(mem_wrEn), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("t6 mem_wrEn drops", 32'(mem_wrEn), 32'd0);
    check_eq("t6 busy drops", 32'(busy), 32'd0);
    check_eq("t6 no ack", 32'(ack), 32'd0);
    step();
    req = '0;
    rst = 1'b0;
    k = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (ack != '0 || busy) k++;
    end
    check_eq("t6 no later ack", 32'(k), 32'd0);
    check_eq("t6 ram[010] unchanged", 32'(ram[12'h010]), 32'h000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
